// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: ID request, EX/WB forwarding sources and registered operand outputs of the operand stage
interface alu_operand_stage_if #(
  parameter int WIDTH  = 32,
  parameter int SA_W   = 5,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic              ALUSrcA;
  logic              ALUSrcB;
  logic [WIDTH-1:0]  ReadData1;
  logic [WIDTH-1:0]  ReadData2;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [SA_W-1:0]   sa;
  logic [WIDTH-1:0]  exten;
  logic              ex_wr_en;
  logic              wb_wr_en;
  logic [ADDR_W-1:0] ex_wr_addr;
  logic [ADDR_W-1:0] wb_wr_addr;
  logic [WIDTH-1:0]  ex_wr_data;
  logic [WIDTH-1:0]  wb_wr_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  rega;
  logic [WIDTH-1:0]  regb;
  logic [WIDTH-1:0]  store_data;
  logic [CNT_W-1:0]  fwd_count;
  modport slave (
    input  in_valid, ALUSrcA, ALUSrcB, ReadData1, ReadData2, rs_addr, rt_addr, sa, exten,
           ex_wr_en, wb_wr_en, ex_wr_addr, wb_wr_addr, ex_wr_data, wb_wr_data, out_ready,
    output in_ready, out_valid, rega, regb, store_data, fwd_count
  );
  modport master (
    output in_valid, ALUSrcA, ALUSrcB, ReadData1, ReadData2, rs_addr, rt_addr, sa, exten,
           ex_wr_en, wb_wr_en, ex_wr_addr, wb_wr_addr, ex_wr_data, wb_wr_data, out_ready,
    input  in_ready, out_valid, rega, regb, store_data, fwd_count
  );
endinterface

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: registered ALU operand select with EX/WB forwarding (macro ALU_OPERAND_FWD_EN) and a one-entry valid/ready output
module alu_operand_stage #(
  parameter int WIDTH  = 32,
  parameter int SA_W   = 5,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input logic CLK,
  input logic Reset,
  alu_operand_stage_if.slave bus
);
  logic [WIDTH-1:0] rs_res, rt_res;
  logic             fwd_hit, acc;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] rega_q, rega_d, regb_q, regb_d, store_q, store_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef ALU_OPERAND_FWD_EN
  logic rs_ex, rs_wb, rt_ex, rt_wb;
  assign rs_ex = bus.ex_wr_en && bus.ex_wr_addr == bus.rs_addr && |bus.rs_addr;
  assign rs_wb = bus.wb_wr_en && bus.wb_wr_addr == bus.rs_addr && |bus.rs_addr;
  assign rt_ex = bus.ex_wr_en && bus.ex_wr_addr == bus.rt_addr && |bus.rt_addr;
  assign rt_wb = bus.wb_wr_en && bus.wb_wr_addr == bus.rt_addr && |bus.rt_addr;
  assign rs_res = rs_ex ? bus.ex_wr_data : rs_wb ? bus.wb_wr_data : bus.ReadData1;
  assign rt_res = rt_ex ? bus.ex_wr_data : rt_wb ? bus.wb_wr_data : bus.ReadData2;
  // rt always reaches store_data, so an rt forward counts even when B takes the immediate
  assign fwd_hit = (!bus.ALUSrcA && (rs_ex || rs_wb)) || rt_ex || rt_wb;
`else
  logic fwd_unused;
  assign fwd_unused = ^{bus.ex_wr_en, bus.wb_wr_en, bus.ex_wr_addr, bus.wb_wr_addr,
                        bus.ex_wr_data, bus.wb_wr_data, bus.rs_addr, bus.rt_addr};
  assign rs_res  = bus.ReadData1;
  assign rt_res  = bus.ReadData2;
  assign fwd_hit = 1'b0;
`endif
  assign bus.in_ready   = !valid_q || bus.out_ready;
  assign acc            = bus.in_valid && bus.in_ready;
  assign bus.out_valid  = valid_q;
  assign bus.rega       = rega_q;
  assign bus.regb       = regb_q;
  assign bus.store_data = store_q;
  assign bus.fwd_count  = cnt_q;
  // next state: load on accept, drop valid on drain-only, otherwise hold
  always_comb begin
    valid_d = acc || (valid_q && !bus.out_ready);
    rega_d  = acc ? (bus.ALUSrcA ? {{(WIDTH-SA_W){1'b0}}, bus.sa} : rs_res) : rega_q;
    regb_d  = acc ? (bus.ALUSrcB ? bus.exten : rt_res) : regb_q;
    store_d = acc ? rt_res : store_q;
    cnt_d   = (acc && fwd_hit && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  // output register with asynchronous clear
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      valid_q <= 1'b0;
      rega_q  <= '0;
      regb_q  <= '0;
      store_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      store_q <= store_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed and random checks of alu_operand_stage against a behavioural model
module tb_alu_operand_stage;
  localparam int W  = 32;
  localparam int SW = 5;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  bit         m_valid;
  logic [W-1:0] m_a, m_b, m_s;
  int         m_cnt;
  alu_operand_stage_if #(.WIDTH(W), .SA_W(SW), .ADDR_W(AW), .CNT_W(CW)) bus ();
  alu_operand_stage #(.WIDTH(W), .SA_W(SW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .CLK(clk),
    .Reset(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] resolve(input logic [AW-1:0] a, input logic [W-1:0] rf, output bit hit);
    hit = 1'b0;
`ifdef ALU_OPERAND_FWD_EN
    if (a != 0 && bus.ex_wr_en && bus.ex_wr_addr == a) begin
      hit = 1'b1;
      return bus.ex_wr_data;
    end
    if (a != 0 && bus.wb_wr_en && bus.wb_wr_addr == a) begin
      hit = 1'b1;
      return bus.wb_wr_data;
    end
`endif
    return rf;
  endfunction
  task automatic check_outputs();
    check("out_valid", W'(bus.out_valid), W'(m_valid));
    check("rega", bus.rega, m_a);
    check("regb", bus.regb, m_b);
    check("store_data", bus.store_data, m_s);
    check("fwd_count", W'(bus.fwd_count), W'(m_cnt));
  endtask
  task automatic model_reset();
    m_valid = 1'b0;
    m_a = '0;
    m_b = '0;
    m_s = '0;
    m_cnt = 0;
  endtask
  task automatic idle();
    bus.in_valid = 0; bus.out_ready = 0; bus.ALUSrcA = 0; bus.ALUSrcB = 0;
    bus.ReadData1 = 0; bus.ReadData2 = 0; bus.rs_addr = 0; bus.rt_addr = 0;
    bus.sa = 0; bus.exten = 0; bus.ex_wr_en = 0; bus.wb_wr_en = 0;
    bus.ex_wr_addr = 0; bus.wb_wr_addr = 0; bus.ex_wr_data = 0; bus.wb_wr_data = 0;
  endtask
  task automatic step();
    bit hrs, hrt;
    logic [W-1:0] rs, rt;
    #1;
    check("in_ready", W'(bus.in_ready), W'(!m_valid || bus.out_ready));
    rs = resolve(bus.rs_addr, bus.ReadData1, hrs);
    rt = resolve(bus.rt_addr, bus.ReadData2, hrt);
    if (bus.in_valid && (!m_valid || bus.out_ready)) begin
      m_valid = 1'b1;
      m_a = bus.ALUSrcA ? W'(bus.sa) : rs;
      m_b = bus.ALUSrcB ? bus.exten : rt;
      m_s = rt;
      if ((!bus.ALUSrcA && hrs) || hrt) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end else if (bus.out_ready) m_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outputs();
  endtask
  task automatic randomize_inputs();
    bus.in_valid = $urandom_range(0, 9) < 8;
    bus.out_ready = $urandom_range(0, 9) < 7;
    bus.ALUSrcA = 1'($urandom);
    bus.ALUSrcB = 1'($urandom);
    bus.ReadData1 = $urandom;
    bus.ReadData2 = $urandom;
    bus.rs_addr = AW'($urandom_range(0, 3));
    bus.rt_addr = AW'($urandom_range(0, 3));
    bus.sa = SW'($urandom);
    bus.exten = $urandom;
    bus.ex_wr_en = 1'($urandom);
    bus.wb_wr_en = 1'($urandom);
    bus.ex_wr_addr = AW'($urandom_range(0, 3));
    bus.wb_wr_addr = AW'($urandom_range(0, 3));
    bus.ex_wr_data = $urandom;
    bus.wb_wr_data = $urandom;
  endtask
  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    // basic select
    bus.in_valid = 1; bus.out_ready = 1; bus.ReadData1 = 32'h11; bus.sa = 5; bus.ALUSrcA = 1;
    bus.exten = 32'hFFFF_FFF0; bus.ALUSrcB = 1;
    step();
    check("basic_rega", bus.rega, 32'h5);
    check("basic_regb", bus.regb, 32'hFFFF_FFF0);
    // forward priority, then register 0
    idle();
    bus.in_valid = 1; bus.out_ready = 1; bus.rs_addr = 3; bus.ReadData1 = 32'h1111;
    bus.ex_wr_en = 1; bus.ex_wr_addr = 3; bus.ex_wr_data = 32'hAAAA;
    bus.wb_wr_en = 1; bus.wb_wr_addr = 3; bus.wb_wr_data = 32'hBBBB;
    step();
`ifdef ALU_OPERAND_FWD_EN
    check("prio_rega", bus.rega, 32'hAAAA);
`else
    check("prio_rega", bus.rega, 32'h1111);
`endif
    bus.rs_addr = 0; bus.ex_wr_addr = 0; bus.wb_wr_addr = 0;
    step();
    check("r0_rega", bus.rega, 32'h1111);
    // back-pressure: accept X, stall 3 cycles with Y pending, then release
    idle();
    bus.in_valid = 1; bus.out_ready = 1; bus.ReadData1 = 32'hC0DE_0001; bus.ReadData2 = 32'hC0DE_0002;
    step();
    bus.out_ready = 0; bus.ReadData1 = 32'hBEEF_0001; bus.ReadData2 = 32'hBEEF_0002;
    repeat (3) begin
      bus.ex_wr_en = 1'($urandom); bus.ex_wr_addr = AW'($urandom_range(0, 3)); bus.ex_wr_data = $urandom;
      step();
      check("stall_hold", bus.rega, 32'hC0DE_0001);
    end
    bus.ex_wr_en = 0; bus.out_ready = 1;
    step();
    check("release_load", bus.rega, 32'hBEEF_0001);
    // store path
    idle();
    bus.in_valid = 1; bus.out_ready = 1; bus.ALUSrcB = 1; bus.exten = 32'h00AB_CDEF;
    bus.rt_addr = 7; bus.ReadData2 = 32'h5555; bus.wb_wr_en = 1; bus.wb_wr_addr = 7; bus.wb_wr_data = 32'h1234;
    step();
    check("store_regb", bus.regb, 32'h00AB_CDEF);
    // saturation: 17 forwarded accepts
    idle();
    bus.in_valid = 1; bus.out_ready = 1; bus.rs_addr = 1;
    bus.ex_wr_en = 1; bus.ex_wr_addr = 1;
    for (int i = 0; i < 17; i++) begin
      bus.ReadData1 = $urandom;
      bus.ex_wr_data = $urandom;
      step();
    end
`ifdef ALU_OPERAND_FWD_EN
    check("sat_count", W'(bus.fwd_count), W'(CNT_MAX));
`else
    check("sat_count", W'(bus.fwd_count), 32'h0);
`endif
    // reset mid-stall
    idle();
    bus.in_valid = 1; bus.out_ready = 1; bus.ReadData1 = 32'h7777; bus.ReadData2 = 32'h8888;
    step();
    bus.out_ready = 0;
    step();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    bus.in_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", W'(bus.in_ready), 32'h1);
    // random traffic
    for (int i = 0; i < 500; i++) begin
      randomize_inputs();
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Registered ALU operand-select stage for the pipelined CPU datapath, between register-file read (ID) and the ALU (EX). It selects operand A (`ReadData1` or zero-extended shift amount `sa`) and operand B (`ReadData2` or extended immediate `exten`). Operands resolve from in-flight EX/WB results via optional forwarding. Results are held in a one-entry valid/ready output register so EX back-pressure stalls ID cleanly.

## Interface
Parameters:
- `WIDTH`, 32: data width of operands and results.
- `SA_W`, 5: width of shift-amount field.
- `ADDR_W`, 5: register address width.
- `CNT_W`, 16: width of forwarding-event counter.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  ID presents a valid operand request.
- `in_ready`  out  1  stage can accept a request this cycle.
- `ALUSrcA`  in  1  1: A = zero-extended `sa`; 0: A = resolved rs value.
- `ALUSrcB`  in  1  1: B = `exten`; 0: B = resolved rt value.
- `ReadData1`, `ReadData2`  in  WIDTH  register-file values for rs and rt.
- `rs_addr`, `rt_addr`  in  ADDR_W  source register numbers.
- `sa`  in  SA_W  shift amount.
- `exten`  in  WIDTH  sign/zero-extended immediate.
- `ex_wr_en`, `wb_wr_en`  in  1  EX / WB stage will write a register.
- `ex_wr_addr`, `wb_wr_addr`  in  ADDR_W  destination registers.
- `ex_wr_data`, `wb_wr_data`  in  WIDTH  result values.
- `out_valid`  out  1  `rega`/`regb`/`store_data` hold a valid operand set.
- `out_ready`  in  1  EX consumes the output this cycle.
- `rega`, `regb`  out  WIDTH  registered ALU operands.
- `store_data`  out  WIDTH  registered resolved rt value, for stores.
- `fwd_count`  out  CNT_W  saturating count of accepted requests that used forwarding.

## Operation
- Resolve rs: if `ex_wr_en && ex_wr_addr==rs_addr && rs_addr!=0`, use `ex_wr_data`. Else apply the same test against WB and use `wb_wr_data`. Else use `ReadData1`. Resolve rt identically from `ReadData2`.
- EX match has priority over WB match. Register 0 never forwards; it resolves to `ReadData1`/`ReadData2` unchanged.
- `rega` = `ALUSrcA ? {(WIDTH-SA_W)'b0, sa} : rs_res`; `regb` = `ALUSrcB ? exten : rt_res`; `store_data` = `rt_res` regardless of `ALUSrcB`.
- `in_ready` = `!out_valid || out_ready`. This is combinational, with no dependency on `in_valid`.
- Accept when `in_valid && in_ready`: load `rega`, `regb` and `store_data`, and set `out_valid`.
- Drain when `out_valid && out_ready` with no accept: clear `out_valid`.
- Accept and drain in the same cycle: new data loads and `out_valid` stays 1.
- While `out_valid && !out_ready`: all outputs hold bit-stable and no request is accepted.
- `fwd_count` increments by 1 on each accept where a forwarded value reached `rega`, `regb` or `store_data`, and saturates at all-ones.
- Reset: `out_valid`=0, `rega`=`regb`=`store_data`=0, `fwd_count`=0. A request in flight during reset is discarded.

## Timing
- Latency is one cycle: a request accepted at edge N is visible on the outputs after edge N.
- Throughput is one request per cycle while `out_ready`=1.
- Forwarding inputs are sampled only on the accepting edge. Changes while the stage is stalled do not alter held outputs.
- `in_ready` depends combinationally on `out_valid` and `out_ready` only.
- Reset asserted asynchronously clears the outputs immediately. Reset deassertion takes effect at the next `CLK` edge.

## Configuration
- `ALU_OPERAND_FWD_EN`: when defined, forwarding logic and `fwd_count` are compiled in as described.
- When undefined: rs resolves to `ReadData1` and rt to `ReadData2`. The `ex_*`/`wb_*` inputs are ignored, and `fwd_count` is tied to 0.

## Test plan
- Reset mid-stall: with `out_valid`=1, `out_ready`=0, assert `Reset` -> `out_valid`=0 and all data 0 immediately; `in_ready`=1 after release.
- Basic select: `ReadData1`=0x11, `sa`=5, `ALUSrcA`=1, `exten`=0xFFFF_FFF0, `ALUSrcB`=1, `out_ready`=1 -> next cycle `rega`=0x5, `regb`=0xFFFF_FFF0, `out_valid`=1.
- Forward priority (macro on): `rs_addr`=3, EX writes r3=0xAAAA, WB writes r3=0xBBBB, `ALUSrcA`=0 -> `rega`=0xAAAA, `fwd_count`=1. Repeat with `rs_addr`=0 -> `rega`=`ReadData1`, count unchanged.
- Back-pressure: accept X, hold `out_ready`=0 for 3 cycles while driving request Y -> outputs stay X and `in_ready`=0. Raise `out_ready` -> Y loads on that edge with `out_valid` still 1.
- Store path: `ALUSrcB`=1, `rt_addr`=7, WB writes r7=0x1234 -> `regb`=`exten`, `store_data`=0x1234.
- Saturation (CNT_W=4): 17 forwarded accepts -> `fwd_count`=0xF. Macro off: same stimulus -> `fwd_count`=0 and raw `ReadData` values on the outputs.
